// File: rtl/mem_1r1w_req_sched.sv
// 1-read/1-write request scheduler in front of a single-port (1rw) SRAM with a 1-cycle read latency.
// Optional same-address write-to-read forwarding on a tie is enabled by defining MEM_SCHED_FWD_EN.
module mem_1r1w_req_sched #(
  parameter int ELS       = 32,
  parameter int WIDTH     = 64,
  parameter int ADDR_W    = $clog2(ELS),
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              w_v_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [WIDTH-1:0]  w_data_i,
  output logic              w_ready_o,
  input  logic              r_v_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              r_ready_o,
  output logic              r_data_v_o,
  output logic [WIDTH-1:0]  r_data_o,
  input  logic              r_yumi_i,
  output logic              mem_v_o,
  output logic              mem_w_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_data_o,
  input  logic [WIDTH-1:0]  mem_data_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic              rr_q, rr_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  fifo_mem [RSP_DEPTH];

  logic              rd_ok, r_req, tie, fwd_hit;
  logic              w_gnt, r_gnt;
  logic              fifo_empty, enq, deq, pop;
  logic [WIDTH-1:0]  rsp_data;

`ifdef MEM_SCHED_FWD_EN
  logic              fwd_sel_q;
  logic [WIDTH-1:0]  fwd_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_sel_q  <= fwd_hit;
      fwd_data_q <= w_data_i;
    end
  end

  assign rsp_data = fwd_sel_q ? fwd_data_q : mem_data_i;
`else
  assign rsp_data = mem_data_i;
`endif

  // Reads only launch when a response slot is guaranteed; a same-cycle yumi is not counted.
  assign rd_ok = (count_q + CNT_W'(inflight_q)) < CNT_W'(RSP_DEPTH);

  always_comb begin
    r_req   = r_v_i & rd_ok;
    tie     = w_v_i & r_req;
`ifdef MEM_SCHED_FWD_EN
    fwd_hit = ~reset_i & tie & (w_addr_i == r_addr_i);
`else
    fwd_hit = 1'b0;
`endif
    w_gnt   = 1'b0;
    r_gnt   = 1'b0;
    rr_d    = rr_q;
    if (!reset_i) begin
      if (fwd_hit) begin
        w_gnt = 1'b1;
        r_gnt = 1'b1;
      end else if (tie) begin
        // rr_q=0: write has priority; after a write win the read gets the next tie.
        w_gnt = ~rr_q;
        r_gnt = rr_q;
        rr_d  = ~rr_q;
      end else begin
        w_gnt = w_v_i;
        r_gnt = r_req;
      end
    end
  end

  assign w_ready_o  = w_gnt;
  assign r_ready_o  = r_gnt;
  assign mem_v_o    = w_gnt | r_gnt;
  assign mem_w_o    = w_gnt;
  assign mem_addr_o = w_gnt ? w_addr_i : r_addr_i;
  assign mem_data_o = w_data_i;

  // Response path: the FIFO head has priority; an empty FIFO lets fresh read data fall through.
  assign fifo_empty = (count_q == '0);
  assign r_data_v_o = ~reset_i & (~fifo_empty | inflight_q);
  assign r_data_o   = fifo_empty ? rsp_data : fifo_mem[rd_ptr_q];
  assign deq        = r_yumi_i & r_data_v_o;
  assign enq        = inflight_q & ~(fifo_empty & deq);
  assign pop        = deq & ~fifo_empty;

  always_comb begin
    inflight_d = r_gnt;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (enq) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (enq && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q       <= 1'b0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_mem[wr_ptr_q] <= rsp_data;
    end
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    r_yumi_i |-> r_data_v_o);

endmodule

// File: tb/tb_mem_1r1w_req_sched.sv
// Directed scoreboard bench for mem_1r1w_req_sched with a behavioural 1-cycle-latency SRAM.
module tb_mem_1r1w_req_sched;
  localparam int ELS       = 32;
  localparam int WIDTH     = 64;
  localparam int ADDR_W    = 5;
  localparam int RSP_DEPTH = 2;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              w_v_i = 1'b0;
  logic [ADDR_W-1:0] w_addr_i = '0;
  logic [WIDTH-1:0]  w_data_i = '0;
  logic              w_ready_o;
  logic              r_v_i = 1'b0;
  logic [ADDR_W-1:0] r_addr_i = '0;
  logic              r_ready_o;
  logic              r_data_v_o;
  logic [WIDTH-1:0]  r_data_o;
  logic              r_yumi_i;
  logic              mem_v_o;
  logic              mem_w_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WIDTH-1:0]  mem_data_o;
  logic [WIDTH-1:0]  mem_data_i;

  logic              yumi_en = 1'b0;
  logic              rst_cmd = 1'b1;
  logic              yumi_cmd = 1'b0;
  logic [WIDTH-1:0]  sram [ELS];
  logic [WIDTH-1:0]  exp_q [$];
  int                total = 0;
  int                bad = 0;

  mem_1r1w_req_sched #(
    .ELS(ELS), .WIDTH(WIDTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_ready_o(r_ready_o),
    .r_data_v_o(r_data_v_o), .r_data_o(r_data_o), .r_yumi_i(r_yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Consumer only takes a response that is actually offered.
  assign r_yumi_i = yumi_en & r_data_v_o;

  initial begin
    for (int a = 0; a < ELS; a++) sram[a] <= 64'h1000 + 64'(a);
    mem_data_i <= '0;
  end

  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
      else         mem_data_i <= sram[mem_addr_o];
    end
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_gnt(input string name, input logic ew, input logic er);
    check(name, {60'd0, w_ready_o, r_ready_o, mem_v_o, mem_w_o}, {60'd0, ew, er, ew | er, ew});
  endfunction

  always @(negedge clk_i) begin
    if (r_data_v_o && r_yumi_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %h expected no response", r_data_o);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("rsp_data", r_data_o, e);
        $display("rsp: data=%h expected=%h", r_data_o, e);
      end
    end
  end

  task automatic step(input logic wv, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic rv, input logic [ADDR_W-1:0] ra);
    @(posedge clk_i);
    #1;
    reset_i  = rst_cmd;
    yumi_en  = yumi_cmd;
    w_v_i    = wv;
    w_addr_i = wa;
    w_data_i = wd;
    r_v_i    = rv;
    r_addr_i = ra;
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with a read held high
    rst_cmd = 1'b1;
    yumi_cmd = 1'b1;
    repeat (2) begin
      step(1'b0, '0, '0, 1'b1, 5'd3);
      expect_gnt("reset_gnt", 1'b0, 1'b0);
      check("reset_rdv", {63'd0, r_data_v_o}, 64'd0);
    end
    rst_cmd = 1'b0;
    idle();
    check("post_reset_outs", {59'd0, w_ready_o, r_ready_o, r_data_v_o, mem_v_o, mem_w_o}, 64'd0);

    // 2: write then read same address
    step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, '0);
    expect_gnt("wr5_gnt", 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 5'd5);
    expect_gnt("rd5_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'hDEAD_BEEF);
    idle();
    check("rd5_latency_v", {63'd0, r_data_v_o}, 64'd1);
    check("rd5_latency_d", r_data_o, 64'hDEAD_BEEF);

    // 3: continuous tie, alternating W,R starting with W
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ADDR_W'(24 + i), 64'hC0 + 64'(i), 1'b1, ADDR_W'(20 + i));
      expect_gnt("tie_gnt", (i % 2) == 0, (i % 2) == 1);
      check("tie_rsp_v", {63'd0, r_data_v_o}, {63'd0, (i > 0) && ((i % 2) == 0)});
      if ((i % 2) == 1) exp_q.push_back(64'h1000 + 64'(20 + i));
    end
    idle();
    check("tie_last_rsp_v", {63'd0, r_data_v_o}, 64'd1);

    // 4: backpressure with a 2-entry response FIFO
    step(1'b1, 5'd1, 64'h11, 1'b0, '0);
    step(1'b1, 5'd2, 64'h22, 1'b0, '0);
    step(1'b1, 5'd3, 64'h33, 1'b0, '0);
    step(1'b1, 5'd4, 64'h44, 1'b0, '0);
    expect_gnt("bp_wr_gnt", 1'b1, 1'b0);
    yumi_cmd = 1'b0;
    step(1'b0, '0, '0, 1'b1, 5'd1);
    expect_gnt("bp_rd1_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'h11);
    step(1'b0, '0, '0, 1'b1, 5'd2);
    expect_gnt("bp_rd2_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'h22);
    step(1'b0, '0, '0, 1'b1, 5'd3);
    expect_gnt("bp_rd3_block_a", 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 5'd3);
    expect_gnt("bp_rd3_block_b", 1'b0, 1'b0);
    check("bp_head", r_data_o, 64'h11);
    yumi_cmd = 1'b1;
    step(1'b0, '0, '0, 1'b1, 5'd3);
    expect_gnt("bp_rd3_block_c", 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 5'd3);
    expect_gnt("bp_rd3_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'h33);
    step(1'b0, '0, '0, 1'b1, 5'd4);
    expect_gnt("bp_rd4_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'h44);
    idle();
    check("bp_last_v", {63'd0, r_data_v_o}, 64'd1);

    // 5: reset the cycle after a read grant
    step(1'b0, '0, '0, 1'b1, 5'd1);
    expect_gnt("mid_rd_gnt", 1'b0, 1'b1);
    rst_cmd = 1'b1;
    idle();
    check("mid_rst_rdv", {63'd0, r_data_v_o}, 64'd0);
    rst_cmd = 1'b0;
    idle();
    check("mid_after_rdv", {63'd0, r_data_v_o}, 64'd0);
    step(1'b1, 5'd9, 64'h99, 1'b1, 5'd8);
    expect_gnt("mid_tie_gnt", 1'b1, 1'b0);
    idle();
    check("mid_tie_rdv", {63'd0, r_data_v_o}, 64'd0);

    // 6: same-address tie (read currently holds round-robin priority)
`ifdef MEM_SCHED_FWD_EN
    step(1'b1, 5'd7, 64'hA5, 1'b1, 5'd7);
    expect_gnt("fwd_tie_gnt", 1'b1, 1'b1);
    exp_q.push_back(64'hA5);
    idle();
    check("fwd_rsp", r_data_o, 64'hA5);
`else
    step(1'b1, 5'd7, 64'hA5, 1'b1, 5'd7);
    expect_gnt("nofwd_tie_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'h1007);
    step(1'b1, 5'd7, 64'hA5, 1'b0, '0);
    expect_gnt("nofwd_wr_gnt", 1'b1, 1'b0);
    check("nofwd_old_data", r_data_o, 64'h1007);
`endif
    step(1'b0, '0, '0, 1'b1, 5'd7);
    expect_gnt("rd7_gnt", 1'b0, 1'b1);
    exp_q.push_back(64'hA5);
    repeat (3) idle();
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
